// File: rtl/encoder_conditioner.sv
// Encoder front end: synchronises and debounces the raw channel, then derives
// edge strobes, a saturating glitch count and a stall flag.
module encoder_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STALL_CYCLES    = 10_000_000,
  parameter int GLITCH_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enc_in,
  output logic                data_out,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [GLITCH_W-1:0] glitch_cnt,
  output logic                stalled
);

  localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STALL_W-1:0]     stall_q, stall_d;
  logic [GLITCH_W-1:0]    glitch_q, glitch_d;
  logic                   data_q, data_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   stalled_q, stalled_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], enc_in};
    cnt_d    = cnt_q;
    data_d   = data_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;

    if (s == data_q) begin
      cnt_d = '0;
      // Input fell back before the new level was accepted.
      if (cnt_q != '0 && glitch_q != '1) glitch_d = glitch_q + 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      data_d = s;
      cnt_d  = '0;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (rise_d)                      stall_d = '0;
    else if (stall_q != STALL_MAX)   stall_d = stall_q + 1'b1;
    else                             stall_d = stall_q;
    stalled_d = (stall_d == STALL_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      stall_q   <= '0;
      glitch_q  <= '0;
      data_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
      glitch_q  <= glitch_d;
      data_q    <= data_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      stalled_q <= stalled_d;
    end
  end

  assign data_out   = data_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign glitch_cnt = glitch_q;
  assign stalled    = stalled_q;

endmodule

// File: tb/tb_encoder_conditioner.sv
// Bench for encoder_conditioner: directed scenarios plus randomized drive
// compared against a sliding-window behavioural model.
module tb_encoder_conditioner;

  localparam int SYNC  = 2;
  localparam int DEB   = 16;
  localparam int STALL = 1000;
  localparam int GW    = 4;
  localparam int GMAX  = (1 << GW) - 1;
  localparam int HALF  = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enc_in = 1'b0;
  logic data_out, rise_pulse, fall_pulse, stalled;
  logic [GW-1:0] glitch_cnt;
  logic d1_data, d1_rise, d1_fall, d1_stalled;
  logic [GW-1:0] d1_glitch;

  int tests_run = 0;
  int failed = 0;
  int cyc = 0;

  encoder_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
                        .STALL_CYCLES(STALL), .GLITCH_W(GW)) dut (
    .clk(clk), .rst(rst), .enc_in(enc_in), .data_out(data_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .glitch_cnt(glitch_cnt), .stalled(stalled));

  encoder_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(1),
                        .STALL_CYCLES(STALL), .GLITCH_W(GW)) dut1 (
    .clk(clk), .rst(rst), .enc_in(enc_in), .data_out(d1_data),
    .rise_pulse(d1_rise), .fall_pulse(d1_fall),
    .glitch_cnt(d1_glitch), .stalled(d1_stalled));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: s lags the sampled input by SYNC edges; a level is accepted once
  // the last DEB values of s all differ from the current output.
  bit pipe[$];
  bit win[$];
  bit m_dout, m_rise, m_fall, m_stalled;
  int m_glitch, m_since;

  always @(posedge clk) begin
    bit s_now, prev_s, all_diff;
    if (rst) begin
      pipe.delete();
      win.delete();
      for (int k = 0; k < SYNC; k++) pipe.push_back(1'b0);
      for (int k = 0; k < DEB; k++) win.push_back(1'b0);
      m_dout = 0; m_rise = 0; m_fall = 0; m_stalled = 0;
      m_glitch = 0; m_since = 0;
    end else begin
      s_now = pipe[$];
      void'(pipe.pop_back());
      pipe.push_front(enc_in);
      prev_s = win[$];
      void'(win.pop_front());
      win.push_back(s_now);
      all_diff = 1;
      foreach (win[k]) if (win[k] == m_dout) all_diff = 0;
      m_rise = 0;
      m_fall = 0;
      if (all_diff) begin
        m_dout = s_now;
        m_rise = s_now;
        m_fall = !s_now;
      end else if (s_now == m_dout && prev_s != m_dout && m_glitch < GMAX) begin
        m_glitch++;
      end
      if (m_rise) m_since = 0;
      else if (m_since < STALL) m_since++;
      m_stalled = (m_since >= STALL);
    end
  end

  task automatic apply_reset(input logic lvl, input int n);
    rst = 1'b1;
    enc_in = lvl;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enc_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if ({data_out, rise_pulse, fall_pulse, stalled, glitch_cnt} !== '0) begin
        failed++;
        $display("FAIL reset_outputs: got %b required 0",
                 {data_out, rise_pulse, fall_pulse, stalled, glitch_cnt});
      end
    end
    rst = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      tests_run++;
      if ({data_out, rise_pulse, d1_data, d1_rise} !==
          {n >= 18, n == 18, n >= 3, n == 3}) begin
        failed++;
        $display("FAIL reset_release_edge %0d: got %b required %b", n,
                 {data_out, rise_pulse, d1_data, d1_rise},
                 {n >= 18, n == 18, n >= 3, n == 3});
      end
    end
    tests_run++;
    if (glitch_cnt !== '0) begin
      failed++;
      $display("FAIL reset_glitch: got %0d required 0", glitch_cnt);
    end
  endtask

  task automatic test_nominal;
    int rises = 0, falls = 0, high_cyc = 0;
    int chg[$];
    apply_reset(1'b0, 3);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 40 * HALF + 40; i++) begin
      if (i < 40 * HALF && i % HALF == 0) begin
        enc_in = ((i / HALF) % 2 == 0);
        chg.push_back(cyc);
      end
      @(negedge clk);
      if (data_out) high_cyc++;
      if (rise_pulse || fall_pulse) begin
        if (rise_pulse) rises++;
        else falls++;
        tests_run++;
        if (chg.size() == 0 || cyc - chg[0] !== 18) begin
          failed++;
          $display("FAIL nominal_latency: got %0d required 18",
                   chg.size() ? cyc - chg[0] : -1);
        end
        if (chg.size() != 0) void'(chg.pop_front());
      end
    end
    tests_run++;
    if (rises !== 20 || falls !== 20) begin
      failed++;
      $display("FAIL nominal_strobes: got %0d/%0d required 20/20", rises, falls);
    end
    tests_run++;
    if (high_cyc !== 20 * HALF) begin
      failed++;
      $display("FAIL nominal_high_time: got %0d required %0d", high_cyc, 20 * HALF);
    end
    tests_run++;
    if (glitch_cnt !== '0 || stalled !== 1'b0) begin
      failed++;
      $display("FAIL nominal_faults: got glitch %0d stalled %b required 0 0",
               glitch_cnt, stalled);
    end
  endtask

  task automatic test_short_pulse;
    int lens[2] = '{10, 16};
    apply_reset(1'b0, 3);
    repeat (5) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      int rises = 0, falls = 0, high_cyc = 0;
      enc_in = 1'b1;
      for (int i = 0; i < lens[p] + 40; i++) begin
        if (i == lens[p]) enc_in = 1'b0;
        @(negedge clk);
        if (rise_pulse) rises++;
        if (fall_pulse) falls++;
        if (data_out) high_cyc++;
      end
      tests_run++;
      if (rises !== p || falls !== p || high_cyc !== (p ? 16 : 0)) begin
        failed++;
        $display("FAIL short_pulse_%0d: got rise %0d fall %0d high %0d required %0d %0d %0d",
                 lens[p], rises, falls, high_cyc, p, p, p ? 16 : 0);
      end
      tests_run++;
      if (glitch_cnt !== GW'(1)) begin
        failed++;
        $display("FAIL short_pulse_glitch_%0d: got %0d required 1", lens[p], glitch_cnt);
      end
    end
  endtask

  task automatic test_bounce;
    int rises = 0, t0, lat = -1;
    apply_reset(1'b0, 3);
    repeat (5) @(negedge clk);
    for (int b = 0; b < 5; b++) begin
      enc_in = 1'b1;
      repeat (3) begin @(negedge clk); if (rise_pulse) rises++; end
      enc_in = 1'b0;
      repeat (3) begin @(negedge clk); if (rise_pulse) rises++; end
    end
    enc_in = 1'b1;
    t0 = cyc;
    repeat (40) begin
      @(negedge clk);
      if (rise_pulse) begin rises++; lat = cyc - t0; end
    end
    tests_run++;
    if (rises !== 1 || lat !== 18) begin
      failed++;
      $display("FAIL bounce_rise: got %0d rises latency %0d required 1 rise latency 18",
               rises, lat);
    end
    tests_run++;
    if (glitch_cnt !== GW'(5)) begin
      failed++;
      $display("FAIL bounce_glitch: got %0d required 5", glitch_cnt);
    end
  endtask

  task automatic test_stall;
    logic prev;
    bit seen = 0;
    apply_reset(1'b0, 3);
    for (int n = 1; n <= STALL; n++) begin
      @(negedge clk);
      if (n == 500 || n == STALL - 1 || n == STALL) begin
        tests_run++;
        if (stalled !== (n == STALL)) begin
          failed++;
          $display("FAIL stall_assert cycle %0d: got %b required %b", n, stalled, n == STALL);
        end
      end
    end
    enc_in = 1'b1;
    prev = stalled;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (rise_pulse) begin
        seen = 1;
        tests_run++;
        if (stalled !== 1'b0 || prev !== 1'b1) begin
          failed++;
          $display("FAIL stall_drop: got stalled %b before %b required 0 before 1",
                   stalled, prev);
        end
      end
      prev = stalled;
    end
    tests_run++;
    if (!seen) begin
      failed++;
      $display("FAIL stall_rise_timeout: got no rise_pulse required one within 40 cycles");
    end
    for (int n = 1; n <= STALL; n++) begin
      @(negedge clk);
      if (n == STALL - 1 || n == STALL) begin
        tests_run++;
        if (stalled !== (n == STALL)) begin
          failed++;
          $display("FAIL stall_reassert cycle %0d: got %b required %b", n, stalled, n == STALL);
        end
      end
    end
  endtask

  task automatic test_saturation;
    apply_reset(1'b0, 3);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      int exp_g;
      enc_in = 1'b1;
      repeat (5) @(negedge clk);
      enc_in = 1'b0;
      repeat (20) @(negedge clk);
      exp_g = (i + 1 > GMAX) ? GMAX : i + 1;
      tests_run++;
      if (int'(glitch_cnt) !== exp_g) begin
        failed++;
        $display("FAIL glitch_saturation pulse %0d: got %0d required %0d", i, glitch_cnt, exp_g);
      end
    end
    tests_run++;
    if (d1_glitch !== '0) begin
      failed++;
      $display("FAIL deb1_glitch: got %0d required 0", d1_glitch);
    end
  endtask

  task automatic test_random;
    int seg = 0;
    bit long_done = 0;
    int errs = 0;
    apply_reset(1'b0, 3);
    for (int i = 0; i < 6000; i++) begin
      if (i == 2000) rst = 1'b1;
      if (i == 2002) rst = 1'b0;
      if (seg == 0) begin
        enc_in = 1'($urandom_range(0, 1));
        if (i >= 3000 && !long_done) begin
          seg = 1300;
          long_done = 1;
        end else begin
          seg = $urandom_range(1, 24);
        end
      end
      seg--;
      @(negedge clk);
      tests_run++;
      if ({data_out, rise_pulse, fall_pulse, stalled} !== {m_dout, m_rise, m_fall, m_stalled} ||
          int'(glitch_cnt) !== m_glitch || (rise_pulse && fall_pulse)) begin
        failed++;
        errs++;
        if (errs <= 10)
          $display("FAIL random cycle %0d: got dro=%b%b%b st=%b g=%0d required %b%b%b st=%b g=%0d",
                   i, data_out, rise_pulse, fall_pulse, stalled, glitch_cnt,
                   m_dout, m_rise, m_fall, m_stalled, m_glitch);
      end
    end
    tests_run++;
    if (d1_glitch !== '0) begin
      failed++;
      $display("FAIL random_deb1_glitch: got %0d required 0", d1_glitch);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_pulse();
    test_bounce();
    test_stall();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
